// File: rtl/jelly_wishbone_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// Holds the FSM state encoding and the log2 helper for counter widths.
package jelly_wishbone_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/jelly_wishbone_arbiter_if.sv
// Bus bundle for the arbiter: NUM requester ports plus the shared port.
// master: arbiter side; slave: requesters and downstream slave side.
interface jelly_wishbone_arbiter_if
    #(
        parameter int NUM          = 4,
        parameter int WB_ADR_WIDTH = 30,
        parameter int WB_DAT_WIDTH = 32,
        parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
    )
    ();

    logic [NUM*WB_ADR_WIDTH-1:0] s_wb_adr_i;
    logic [NUM*WB_DAT_WIDTH-1:0] s_wb_dat_i;
    logic [WB_DAT_WIDTH-1:0]     s_wb_dat_o;
    logic [NUM-1:0]              s_wb_we_i;
    logic [NUM*WB_SEL_WIDTH-1:0] s_wb_sel_i;
    logic [NUM-1:0]              s_wb_stb_i;
    logic [NUM-1:0]              s_wb_ack_o;

    logic [WB_ADR_WIDTH-1:0]     m_wb_adr_o;
    logic [WB_DAT_WIDTH-1:0]     m_wb_dat_o;
    logic [WB_DAT_WIDTH-1:0]     m_wb_dat_i;
    logic                        m_wb_we_o;
    logic [WB_SEL_WIDTH-1:0]     m_wb_sel_o;
    logic                        m_wb_stb_o;
    logic                        m_wb_ack_i;

    modport master (
        input  s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        output s_wb_dat_o, s_wb_ack_o,
        output m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o,
        input  m_wb_dat_i, m_wb_ack_i
    );

    modport slave (
        output s_wb_adr_i, s_wb_dat_i, s_wb_we_i, s_wb_sel_i, s_wb_stb_i,
        input  s_wb_dat_o, s_wb_ack_o,
        input  m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o,
        output m_wb_dat_i, m_wb_ack_i
    );

endinterface

// File: rtl/jelly_round_robin_select.sv
// Combinational round-robin pick: first request at or after last+1.
// Ports: req (requests), last (previous winner) -> sel (one-hot), idx, valid.
module jelly_round_robin_select
    #(
        parameter int NUM   = 4,
        parameter int IDX_W = 2
    )
    (
        input  logic [NUM-1:0]   req,
        input  logic [IDX_W-1:0] last,
        output logic [NUM-1:0]   sel,
        output logic [IDX_W-1:0] idx,
        output logic             valid
    );

    logic [IDX_W-1:0] k;

    always_comb begin
        sel   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = '0;
        for (int i = 0; i < NUM; i++) begin
            k = IDX_W'((int'(last) + 1 + i) % NUM);
            if (!valid && req[k]) begin
                valid  = 1'b1;
                idx    = k;
                sel[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jelly_wishbone_arbiter.sv
// Round-robin arbiter sharing one stb/ack Wishbone port among NUM requesters.
// Ports: clk, reset (sync, active-high), bus (requester + shared port bundle),
// grant_o (one-hot grant, 0 when idle), timeout_o (watchdog abort pulse).
// Optional ack watchdog: define JELLY_WISHBONE_ARBITER_TIMEOUT_EN.
module jelly_wishbone_arbiter
    import jelly_wishbone_arbiter_pkg::*;
    #(
        parameter int NUM            = 4,
        parameter int WB_ADR_WIDTH   = 30,
        parameter int WB_DAT_WIDTH   = 32,
        parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
        parameter int TIMEOUT_CYCLES = 256
    )
    (
        input  logic                  clk,
        input  logic                  reset,
        jelly_wishbone_arbiter_if.master bus,
        output logic [NUM-1:0]        grant_o,
        output logic                  timeout_o
    );

    localparam int IDX_W = clog2(NUM);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] gnt_next;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] last_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rr_idx;
    logic [NUM-1:0]   rr_sel;
    logic             rr_valid;
    logic [NUM-1:0]   gnt_oh;
    logic             busy;
    logic             stb;
    logic             hit;
    logic             tout;
    logic             unused_rr;

    jelly_round_robin_select
        #(
            .NUM   (NUM),
            .IDX_W (IDX_W)
        )
        u_select
        (
            .req   (bus.s_wb_stb_i),
            .last  (last),
            .sel   (rr_sel),
            .idx   (rr_idx),
            .valid (rr_valid)
        );

    assign unused_rr = ^rr_sel;

    assign busy   = (state == ST_BUSY);
    // Mux index parks on slice 0 while idle.
    assign idx    = busy ? gnt : '0;
    assign gnt_oh = NUM'(1) << gnt;
    assign stb    = busy & bus.s_wb_stb_i[gnt];
    assign hit    = bus.m_wb_ack_i & bus.m_wb_stb_o;

`ifdef JELLY_WISHBONE_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (clog2(TIMEOUT_CYCLES) < 8) ? 8 : clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Cleared whenever idle, so every grant starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset || !busy) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tout = busy && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tout = 1'b0;
`endif

    assign bus.m_wb_adr_o = bus.s_wb_adr_i[int'(idx)*WB_ADR_WIDTH +: WB_ADR_WIDTH];
    assign bus.m_wb_dat_o = bus.s_wb_dat_i[int'(idx)*WB_DAT_WIDTH +: WB_DAT_WIDTH];
    assign bus.m_wb_sel_o = bus.s_wb_sel_i[int'(idx)*WB_SEL_WIDTH +: WB_SEL_WIDTH];
    assign bus.m_wb_we_o  = bus.s_wb_we_i[idx];
    assign bus.m_wb_stb_o = stb & ~tout;

    // A watchdog abort completes the transaction with a forged ack and zero data.
    assign bus.s_wb_ack_o = (hit || tout) ? gnt_oh : '0;
    assign bus.s_wb_dat_o = tout ? '0 : bus.m_wb_dat_i;

    assign grant_o   = busy ? gnt_oh : '0;
    assign timeout_o = tout;

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        last_next  = last;
        unique case (state)
            ST_IDLE: begin
                if (rr_valid) begin
                    state_next = ST_BUSY;
                    gnt_next   = rr_idx;
                end
            end
            ST_BUSY: begin
                if (hit || tout) begin
                    state_next = ST_IDLE;
                    last_next  = gnt;
                end else if (!bus.s_wb_stb_i[gnt]) begin
                    // Withdrawal does not advance the rotation.
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            gnt   <= '0;
            last  <= IDX_W'(NUM - 1);
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            last  <= last_next;
        end
    end

endmodule

// File: doc/jelly_wishbone_arbiter.md
# jelly_wishbone_arbiter

Round-robin arbiter that shares one Wishbone master port (single downstream slave or bridge) between NUM upstream requesters using the codebase's stb/ack-only Wishbone subset (no cyc). It grants one requester at a time and holds the grant for the whole transaction. It muxes address, data, we and sel to the shared port and routes ack back only to the granted requester. It sits between multiple bus masters (CPU, DMA, debug) and a `jelly_wishbone_bridge` or peripheral.

## Interface
- NUM, 4: number of requesters (2..16)
- WB_ADR_WIDTH, 30: address width
- WB_DAT_WIDTH, 32: data width
- WB_SEL_WIDTH, WB_DAT_WIDTH/8: byte-select width
- TIMEOUT_CYCLES, 256: ack watchdog limit; used only with the timeout feature
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_wb_adr_i  in  NUM*WB_ADR_WIDTH  requester addresses, requester i at slice i
- s_wb_dat_i  in  NUM*WB_DAT_WIDTH  requester write data
- s_wb_dat_o  out  WB_DAT_WIDTH  read data, broadcast to all requesters
- s_wb_we_i  in  NUM  write enables
- s_wb_sel_i  in  NUM*WB_SEL_WIDTH  byte selects
- s_wb_stb_i  in  NUM  strobes
- s_wb_ack_o  out  NUM  acks, one-hot or zero
- m_wb_adr_o / m_wb_dat_o / m_wb_we_o / m_wb_sel_o  out  widths as above  muxed from the granted requester
- m_wb_dat_i  in  WB_DAT_WIDTH  shared-port read data
- m_wb_stb_o  out  1  shared-port strobe
- m_wb_ack_i  in  1  shared-port ack
- grant_o  out  NUM  one-hot current grant; zero when idle
- timeout_o  out  1  one-cycle pulse on watchdog abort; tied 0 when the feature is compiled out

## Operation
- State machine with two states:
  - IDLE: no grant; m_wb_stb_o = 0; all s_wb_ack_o = 0.
  - BUSY: holds registered grant index `gnt`.
- IDLE to BUSY: if any s_wb_stb_i is set, `gnt` is the first requester at or after `(last+1) mod NUM` with stb set.
  - `last` resets to NUM-1, so requester 0 has first priority after reset.
- In BUSY:
  - m_wb_adr/dat/we/sel_o = slice `gnt`.
  - m_wb_stb_o = s_wb_stb_i[gnt].
  - s_wb_ack_o[gnt] = m_wb_ack_i & m_wb_stb_o.
  - s_wb_dat_o = m_wb_dat_i, combinational.
- BUSY to IDLE on either of:
  - m_wb_ack_i & m_wb_stb_o (transaction done); `last` <= `gnt`.
  - s_wb_stb_i[gnt] = 0 (requester withdrew); `last` is unchanged.
- Requests from non-granted requesters are held off, with their ack at 0, until they win arbitration.
- Reset values: state IDLE, gnt 0, last NUM-1, grant_o 0, m_wb_stb_o 0, s_wb_ack_o 0, timeout_o 0.
  - m_wb_adr/dat/we/sel_o show slice 0 while idle. Their value is don't-care when stb is 0.
- Reset asserted mid-transaction drops m_wb_stb_o on the next edge. Any late m_wb_ack_i is ignored while IDLE.

## Timing
- Arbitration latency: requester stb rises in cycle 0 (IDLE) → m_wb_stb_o and grant_o set in cycle 1.
- Ack is combinational pass-through, with zero added latency.
- After an ack in cycle n, the state is IDLE in cycle n+1 and the next grant is visible in cycle n+2. This gives a one-cycle bubble between transactions, including back-to-back transactions from the same requester.
- Simultaneous requests resolve by rotating priority. A requester that is continuously requesting waits at most NUM-1 transactions.

## Configuration
- JELLY_WISHBONE_ARBITER_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entering BUSY and increments every BUSY cycle without an ack.
  - When the counter reaches TIMEOUT_CYCLES-1, that cycle:
    - s_wb_ack_o[gnt] = 1;
    - s_wb_dat_o = 0;
    - m_wb_stb_o = 0;
    - timeout_o = 1.
  - The next state is IDLE and `last` <= `gnt`.
- Macro undefined: no counter, timeout_o = 0, and BUSY waits indefinitely for ack.

## Structure
- Shared package `jelly_wishbone_arbiter_pkg` holds:
  - state encoding localparams (ST_IDLE = 0, ST_BUSY = 1);
  - the counter-width function clog2(TIMEOUT_CYCLES).
- Sub-module `jelly_round_robin_select`: combinational. Inputs are the request vector and `last`; outputs are a one-hot selection and its index plus a `valid` flag. It is reusable by other arbiters.

## Test plan
- Single request: NUM=4, requester 2 reads adr 0x100, slave acks after 3 cycles with 0xDEADBEEF. Expect m_wb_stb_o in cycle 1, s_wb_ack_o = 4'b0100 for one cycle, s_wb_dat_o = 0xDEADBEEF, grant_o = 0 afterwards.
- Contention: all 4 requesters hold stb from reset, slave acks immediately. Expect grant order 0,1,2,3,0 with one idle cycle between grants, and no ack ever on a non-granted requester.
- Withdrawal: requester 1 is granted, then drops stb before any ack. Expect m_wb_stb_o = 0 the same cycle, IDLE next, and requester 3 (pending) granted after that.
- Reset mid-operation: assert reset while BUSY with requester 3 writing. Expect m_wb_stb_o = 0 and grant_o = 0 after the edge; requester 0 wins first after reset release.
- Write mux: requester 1 writes adr 0x2A, dat 0x12345678, sel 4'b0011. Expect those exact values on the m port with we = 1 while granted.
- Timeout, with macro defined and TIMEOUT_CYCLES = 16: slave never acks. Expect s_wb_ack_o for the granted requester and timeout_o = 1 in the 16th BUSY cycle, s_wb_dat_o = 0, and m_wb_stb_o low from that cycle.
